// File: rtl/wr_stage_ctrl.sv
// Write-back stage sequencer: holds the WR register across load misses and
// cache-maintenance ops, and issues a one-cycle flush/redirect after refetch points.
module wr_stage_ctrl #(
  parameter logic [31:0] RESET_PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        WR_valid,
  input  logic [31:0] WR_pc,
  input  logic        WR_ex_valid,
  input  logic        WR_unhit,
  input  logic        mem_data_ok,
  input  logic [4:0]  WR_cache_op,
  input  logic [31:0] WR_cache_paddr,
  input  logic        WR_crefetch,
  input  logic        WR_inst_refetch,
  output logic        icache_op_req,
  output logic        dcache_op_req,
  output logic [2:0]  cache_op_code,
  output logic [31:0] cache_op_addr,
  input  logic        icache_op_ack,
  input  logic        dcache_op_ack,
  output logic        WR_wr,
  output logic        wr_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CREQ    = 2'd2;
  localparam logic [1:0] S_REFETCH = 2'd3;

  logic [1:0] state, state_nxt, post_hit;
  logic       op_tgt;
  logic       ack_match;

  // ack only counts when it comes from the cache we actually asked
  assign ack_match = op_tgt ? dcache_op_ack : icache_op_ack;

  always_comb begin
    post_hit  = WR_cache_op[4] ? S_CREQ : (WR_inst_refetch ? S_REFETCH : S_IDLE);
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (WR_valid && !WR_ex_valid) begin
          if (WR_unhit && !mem_data_ok) state_nxt = S_WAIT;
          else                          state_nxt = post_hit;
        end
      end
      S_WAIT:    if (mem_data_ok) state_nxt = post_hit;
      S_CREQ:    if (ack_match) state_nxt = (WR_crefetch || !op_tgt) ? S_REFETCH : S_IDLE;
      S_REFETCH: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // register advances when nothing holds it, including the data-return cycle of a miss
  assign WR_wr = (state == S_REFETCH) ||
                 (((state == S_IDLE) || (state == S_WAIT)) && (state_nxt == S_IDLE));
  assign wr_flush       = (state == S_REFETCH);
  assign redirect_valid = (state == S_REFETCH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      op_tgt        <= 1'b0;
      icache_op_req <= 1'b0;
      dcache_op_req <= 1'b0;
      cache_op_code <= 3'd0;
      cache_op_addr <= 32'd0;
      redirect_pc   <= 32'd0;
      stall_cycles  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state != S_CREQ && state_nxt == S_CREQ) begin
        op_tgt        <= WR_cache_op[3];
        icache_op_req <= !WR_cache_op[3];
        dcache_op_req <= WR_cache_op[3];
        cache_op_code <= WR_cache_op[2:0];
        cache_op_addr <= WR_cache_paddr;
      end else if (state == S_CREQ && ack_match) begin
        icache_op_req <= 1'b0;
        dcache_op_req <= 1'b0;
      end
      if (state != S_REFETCH && state_nxt == S_REFETCH)
        redirect_pc <= WR_pc + RESET_PC_INC;
      if (!WR_wr && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
